axis_bram_reader: RTL and testbench
===================================

AXIS_BRAM_READER -- requirements
Module: axis_bram_reader

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32: output stream data width.
REQ-002 SHALL have parameter BRAM_DATA_WIDTH, default 32: BRAM read data width; must equal AXIS_TDATA_WIDTH.
REQ-003 SHALL have parameter BRAM_ADDR_WIDTH, default 10: BRAM address width.
REQ-004 SHALL have parameter CONTINUOUS, default 1: 1 = wrap and repeat; 0 = one-shot.
REQ-005 SHALL have port aclk  in  1  the single clock.
REQ-006 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cfg_data  in  BRAM_ADDR_WIDTH  number of words N to read per pass.
REQ-008 SHALL have port sts_data  out  BRAM_ADDR_WIDTH  next address to be issued.
REQ-009 SHALL have ports m_axis_tdata (out, AXIS_TDATA_WIDTH), m_axis_tvalid (out, 1) and m_axis_tready (in, 1): master stream.
REQ-010 SHALL have ports b_bram_clk (out, 1, equals aclk), b_bram_rst (out, 1, equals ~aresetn), b_bram_en (out, 1), b_bram_addr (out, BRAM_ADDR_WIDTH) and b_bram_rdata (in, BRAM_DATA_WIDTH): BRAM read port.

Function
REQ-011 SHALL treat BRAM read latency as exactly 1 cycle: data for an address issued with b_bram_en=1 at edge k is valid on b_bram_rdata at edge k+1.
REQ-012 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-013 IDLE SHALL go to RUN when cfg_data != 0; with cfg_data == 0 it stays in IDLE, and no reads or beats occur.
REQ-014 RUN SHALL issue address addr_reg (b_bram_en=1) only when buffer occupancy + in-flight reads < 2, and addr_reg SHALL increment on each issue.
REQ-015 On issuing address N-1: with CONTINUOUS=1, addr_reg SHALL wrap to 0 and the FSM stays in RUN; with CONTINUOUS=0, the FSM SHALL go to DRAIN.
REQ-016 DRAIN SHALL go to DONE when the buffer is empty and no read is in flight; DONE SHALL hold, with no reads and tvalid=0, until reset.
REQ-017 The 2-entry output buffer SHALL capture b_bram_rdata one cycle after each issue, present it in order, and allow push and pop in the same cycle.
REQ-018 m_axis_tvalid SHALL equal buffer non-empty, and once asserted, tdata SHALL stay stable until tready.
REQ-019 With tready held at 1 in RUN, throughput SHALL be 1 beat/cycle, and first-beat latency from entering RUN SHALL be 2 cycles.
REQ-020 With tready=0, no data SHALL be lost or duplicated, and issuing SHALL stall once the buffer plus in-flight reads reaches 2.
REQ-021 cfg_data SHALL be sampled into a register on the IDLE->RUN transition; later changes SHALL have no effect until reset.
REQ-022 When N is 2^BRAM_ADDR_WIDTH (cfg_data=0 cannot express it), that pass length SHALL be unsupported, and the maximum pass SHALL be 2^BRAM_ADDR_WIDTH-1 words.
REQ-023 sts_data SHALL equal addr_reg.

Reset
REQ-024 Asserting aresetn low SHALL immediately and asynchronously set state=IDLE, addr_reg=0, buffer empty, in-flight cleared, m_axis_tvalid=0 and b_bram_en=0.
REQ-025 A reset in mid-pass SHALL discard buffered and in-flight data, and the next pass SHALL restart at address 0.

Configuration
REQ-026 SHALL use macro AXIS_BRAM_READER_TLAST_EN.
REQ-027 With AXIS_BRAM_READER_TLAST_EN defined, the block SHALL add port m_axis_tlast (out, 1), asserted with the beat read from address N-1 (every pass) and 0 after reset.
REQ-028 Without AXIS_BRAM_READER_TLAST_EN, m_axis_tlast SHALL be absent, and no per-entry last flag SHALL be stored.

Structure
REQ-029 Package axis_bram_reader_pkg SHALL hold the FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3) and the constant BUF_DEPTH=2.
REQ-030 The 2-entry buffer SHALL be the sub-module axis_bram_reader_buf (data plus optional last flag, push/pop, count output).

Verification
REQ-031 Bench SHALL cover: BRAM model holds addr*3, cfg_data=4, CONTINUOUS=0, tready=1 -> beats 0,3,6,9; then state DONE, tvalid=0, sts_data=4.
REQ-032 Bench SHALL cover: CONTINUOUS=1, cfg_data=3, tready=1 -> beats 0,3,6,0,3,6,...; tlast on every third beat when the macro is defined.
REQ-033 Bench SHALL cover: tready toggled pseudo-randomly, cfg_data=16 -> exactly 16 in-order beats and tdata stable while tvalid && !tready.
REQ-034 Bench SHALL cover: cfg_data=0 held for 20 cycles -> b_bram_en never 1 and tvalid never 1.
REQ-035 Bench SHALL cover: aresetn pulsed low mid-pass on beat 5 of 10 -> tvalid drops immediately, and after release the stream restarts at value 0.
REQ-036 Bench SHALL cover: tready=0 from the start, cfg_data=8 -> exactly 2 reads issued, sts_data=2, then the stall holds.

Source files
------------

// File: rtl/axis_bram_reader_pkg.sv
// rtl/axis_bram_reader_pkg.sv - shared FSM encoding and buffer sizing for axis_bram_reader
package axis_bram_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int BUF_DEPTH = 2;
   localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/axis_bram_reader_buf.sv
// rtl/axis_bram_reader_buf.sv - 2-entry output buffer, simultaneous push/pop
// Stores a per-entry last flag only when AXIS_BRAM_READER_TLAST_EN is defined.
module axis_bram_reader_buf
   import axis_bram_reader_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
`ifdef AXIS_BRAM_READER_TLAST_EN
   input  logic             push_last,
   output logic             last,
`endif
   input  logic             pop,
   output logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [BUF_DEPTH];
   // One-bit pointers are sufficient because the buffer holds exactly two entries.
   logic             wr_ptr;
   logic             rd_ptr;
   logic             do_pop;

   assign do_pop = pop && (count != '0);
   assign data   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= ~wr_ptr;
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

`ifdef AXIS_BRAM_READER_TLAST_EN
   logic last_mem [BUF_DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_mem[0] <= 1'b0;
         last_mem[1] <= 1'b0;
      end else if (push) begin
         last_mem[wr_ptr] <= push_last;
      end
   end

   assign last = last_mem[rd_ptr] && (count != '0);
`endif

endmodule

// File: rtl/axis_bram_reader.sv
// rtl/axis_bram_reader.sv - streams N BRAM words per pass onto an AXI-Stream master
// Optional m_axis_tlast on the word from address N-1 via AXIS_BRAM_READER_TLAST_EN.
module axis_bram_reader
   import axis_bram_reader_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int BRAM_DATA_WIDTH  = 32,
   parameter int BRAM_ADDR_WIDTH  = 10,
   parameter int CONTINUOUS       = 1
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_data,
   output logic [BRAM_ADDR_WIDTH-1:0]  sts_data,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
`ifdef AXIS_BRAM_READER_TLAST_EN
   output logic                        m_axis_tlast,
`endif
   output logic                        b_bram_clk,
   output logic                        b_bram_rst,
   output logic                        b_bram_en,
   output logic [BRAM_ADDR_WIDTH-1:0]  b_bram_addr,
   input  logic [BRAM_DATA_WIDTH-1:0]  b_bram_rdata
);

   state_t                     state;
   logic [BRAM_ADDR_WIDTH-1:0] addr_reg;
   logic [BRAM_ADDR_WIDTH-1:0] len_reg;
   logic                       inflight;
   logic [CNT_W-1:0]           count;
   logic                       pop;
   logic                       issue;
   logic                       last_addr;

   assign pop       = m_axis_tvalid && m_axis_tready;
   assign last_addr = (addr_reg == len_reg - BRAM_ADDR_WIDTH'(1));
   // Occupancy is credited with this cycle's pop so a ready sink sees one beat per cycle.
   assign issue     = (state == RUN) &&
                      ((count + CNT_W'(inflight) - CNT_W'(pop)) < CNT_W'(BUF_DEPTH));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= IDLE;
         addr_reg <= '0;
         len_reg  <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         case (state)
            IDLE: begin
               if (cfg_data != '0) begin
                  len_reg <= cfg_data;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (issue) begin
                  if (last_addr && (CONTINUOUS != 0)) begin
                     addr_reg <= '0;
                  end else begin
                     addr_reg <= addr_reg + BRAM_ADDR_WIDTH'(1);
                     if (last_addr)
                        state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if ((count == '0) && !inflight)
                  state <= DONE;
            end
            DONE:    state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AXIS_BRAM_READER_TLAST_EN
   logic inflight_last;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         inflight_last <= 1'b0;
      else
         inflight_last <= issue && last_addr;
   end
`endif

   axis_bram_reader_buf #(
      .WIDTH     (AXIS_TDATA_WIDTH)
   ) u_buf (
      .clk       (aclk),
      .rst_n     (aresetn),
      .push      (inflight),
      .push_data (b_bram_rdata),
`ifdef AXIS_BRAM_READER_TLAST_EN
      .push_last (inflight_last),
      .last      (m_axis_tlast),
`endif
      .pop       (m_axis_tready),
      .data      (m_axis_tdata),
      .count     (count)
   );

   assign m_axis_tvalid = (count != '0);
   assign sts_data      = addr_reg;
   assign b_bram_clk    = aclk;
   assign b_bram_rst    = ~aresetn;
   assign b_bram_en     = issue;
   assign b_bram_addr   = addr_reg;

endmodule

// File: tb/tb_axis_bram_reader.sv
// tb/tb_axis_bram_reader.sv - self-checking bench for axis_bram_reader (one-shot and continuous instances)
module tb_axis_bram_reader;

   localparam int AW = 10;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          aresetn;
   logic [AW-1:0] cfg_os, cfg_ct, sts_os, sts_ct, addr_os, addr_ct;
   logic [DW-1:0] tdata_os, tdata_ct, rdata_os, rdata_ct;
   logic          tvalid_os, tvalid_ct, tready_os, tready_ct;
   logic          en_os, en_ct, bclk_os, bclk_ct, brst_os, brst_ct;
`ifdef AXIS_BRAM_READER_TLAST_EN
   logic          tlast_os, tlast_ct;
`endif

   logic [DW-1:0] mem [1<<AW];
   int checks = 0;
   int errors = 0;

   axis_bram_reader #(.AXIS_TDATA_WIDTH(DW), .BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .CONTINUOUS(0)) dut_os (
      .aclk(clk), .aresetn(aresetn), .cfg_data(cfg_os), .sts_data(sts_os),
      .m_axis_tdata(tdata_os), .m_axis_tvalid(tvalid_os), .m_axis_tready(tready_os),
`ifdef AXIS_BRAM_READER_TLAST_EN
      .m_axis_tlast(tlast_os),
`endif
      .b_bram_clk(bclk_os), .b_bram_rst(brst_os), .b_bram_en(en_os),
      .b_bram_addr(addr_os), .b_bram_rdata(rdata_os));

   axis_bram_reader #(.AXIS_TDATA_WIDTH(DW), .BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .CONTINUOUS(1)) dut_ct (
      .aclk(clk), .aresetn(aresetn), .cfg_data(cfg_ct), .sts_data(sts_ct),
      .m_axis_tdata(tdata_ct), .m_axis_tvalid(tvalid_ct), .m_axis_tready(tready_ct),
`ifdef AXIS_BRAM_READER_TLAST_EN
      .m_axis_tlast(tlast_ct),
`endif
      .b_bram_clk(bclk_ct), .b_bram_rst(brst_ct), .b_bram_en(en_ct),
      .b_bram_addr(addr_ct), .b_bram_rdata(rdata_ct));

   // One-cycle-latency BRAM models sharing one content array.
   always @(posedge clk) if (en_os) rdata_os <= mem[addr_os];
   always @(posedge clk) if (en_ct) rdata_ct <= mem[addr_ct];

   task automatic fill_linear();
      for (int i = 0; i < (1<<AW); i++) mem[i] = DW'(i * 3);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      cfg_os = '0; cfg_ct = '0; tready_os = 1'b0; tready_ct = 1'b0;
      repeat (3) @(negedge clk);
      aresetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      cfg_os = '0; cfg_ct = '0; tready_os = 1'b1; tready_ct = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (tvalid_os !== 1'b0 || tvalid_ct !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b/%b expected 0/0", tvalid_os, tvalid_ct); end
      checks++; if (en_os !== 1'b0 || en_ct !== 1'b0) begin errors++; $display("FAIL reset_en: got %b/%b expected 0/0", en_os, en_ct); end
      checks++; if (sts_os !== '0 || sts_ct !== '0) begin errors++; $display("FAIL reset_sts: got %0d/%0d expected 0/0", sts_os, sts_ct); end
      checks++; if (brst_os !== 1'b1) begin errors++; $display("FAIL reset_bram_rst: got %b expected 1", brst_os); end
      checks++; if (2'(dut_os.state) !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dut_os.state); end
`ifdef AXIS_BRAM_READER_TLAST_EN
      checks++; if (tlast_os !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", tlast_os); end
`endif
      aresetn = 1'b1;
      @(negedge clk);
      checks++; if (brst_os !== 1'b0) begin errors++; $display("FAIL release_bram_rst: got %b expected 0", brst_os); end
   endtask

   task automatic test_oneshot();
      logic [DW-1:0] exp_q [$];
      int n = 0, first = -1, lastc = -1;
      do_reset();
      fill_linear();
      for (int i = 0; i < 4; i++) exp_q.push_back(DW'(i * 3));
      tready_os = 1'b1;
      cfg_os = AW'(4);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (tvalid_os && tready_os) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL oneshot_extra_beat: got %0d expected none", tdata_os); end
            else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               if (tdata_os !== e) begin errors++; $display("FAIL oneshot_data: got %0d expected %0d", tdata_os, e); end
            end
`ifdef AXIS_BRAM_READER_TLAST_EN
            checks++; if (tlast_os !== (n == 3)) begin errors++; $display("FAIL oneshot_tlast beat %0d: got %b expected %b", n, tlast_os, (n == 3)); end
`endif
            if (first < 0) first = cyc;
            lastc = cyc;
            n++;
         end
      end
      checks++; if (n != 4) begin errors++; $display("FAIL oneshot_count: got %0d expected 4", n); end
      checks++; if (first != 3) begin errors++; $display("FAIL oneshot_latency: got %0d expected 3", first); end
      checks++; if (lastc - first != 3) begin errors++; $display("FAIL oneshot_throughput: got span %0d expected 3", lastc - first); end
      checks++; if (2'(dut_os.state) !== 2'd3) begin errors++; $display("FAIL oneshot_state: got %0d expected 3", dut_os.state); end
      checks++; if (tvalid_os !== 1'b0) begin errors++; $display("FAIL oneshot_done_tvalid: got %b expected 0", tvalid_os); end
      checks++; if (sts_os !== AW'(4)) begin errors++; $display("FAIL oneshot_sts: got %0d expected 4", sts_os); end
   endtask

   task automatic test_continuous();
      int n = 0, prev = -1;
      do_reset();
      fill_linear();
      tready_ct = 1'b1;
      cfg_ct = AW'(3);
      for (int cyc = 1; cyc <= 40 && n < 12; cyc++) begin
         @(negedge clk);
         if (tvalid_ct && tready_ct) begin
            checks++; if (tdata_ct !== DW'((n % 3) * 3)) begin errors++; $display("FAIL cont_data beat %0d: got %0d expected %0d", n, tdata_ct, (n % 3) * 3); end
`ifdef AXIS_BRAM_READER_TLAST_EN
            checks++; if (tlast_ct !== ((n % 3) == 2)) begin errors++; $display("FAIL cont_tlast beat %0d: got %b expected %b", n, tlast_ct, ((n % 3) == 2)); end
`endif
            if (prev >= 0) begin
               checks++; if (cyc != prev + 1) begin errors++; $display("FAIL cont_gap beat %0d: got cycle %0d expected %0d", n, cyc, prev + 1); end
            end
            prev = cyc;
            n++;
         end
      end
      checks++; if (n != 12) begin errors++; $display("FAIL cont_count: got %0d expected 12", n); end
   endtask

   task automatic test_random_ready();
      logic [DW-1:0] exp_q [$];
      logic [DW-1:0] prev_data = '0;
      logic          prev_stall = 1'b0;
      int n = 0;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         mem[i] = $urandom;
         exp_q.push_back(mem[i]);
      end
      cfg_os = AW'(16);
      for (int cyc = 1; cyc <= 400 && n < 16; cyc++) begin
         @(negedge clk);
         if (prev_stall) begin
            checks++;
            if (tvalid_os !== 1'b1 || tdata_os !== prev_data) begin errors++; $display("FAIL rand_stable: got %b/%h expected 1/%h", tvalid_os, tdata_os, prev_data); end
         end
         tready_os = 1'($urandom_range(0, 1));
         if (tvalid_os && tready_os) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            checks++; if (tdata_os !== e) begin errors++; $display("FAIL rand_data beat %0d: got %h expected %h", n, tdata_os, e); end
`ifdef AXIS_BRAM_READER_TLAST_EN
            checks++; if (tlast_os !== (n == 15)) begin errors++; $display("FAIL rand_tlast beat %0d: got %b expected %b", n, tlast_os, (n == 15)); end
`endif
            n++;
         end
         prev_stall = tvalid_os && !tready_os;
         prev_data  = tdata_os;
      end
      checks++; if (n != 16) begin errors++; $display("FAIL rand_count: got %0d expected 16", n); end
      tready_os = 1'b1;
      repeat (10) begin
         @(negedge clk);
         checks++; if (tvalid_os !== 1'b0) begin errors++; $display("FAIL rand_extra_beat: got %h expected no beat", tdata_os); end
      end
      checks++; if (2'(dut_os.state) !== 2'd3) begin errors++; $display("FAIL rand_state: got %0d expected 3", dut_os.state); end
   endtask

   task automatic test_zero_cfg();
      do_reset();
      tready_os = 1'b1; tready_ct = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         checks++; if (en_os || en_ct) begin errors++; $display("FAIL zero_en cycle %0d: got %b/%b expected 0/0", cyc, en_os, en_ct); end
         checks++; if (tvalid_os || tvalid_ct) begin errors++; $display("FAIL zero_tvalid cycle %0d: got %b/%b expected 0/0", cyc, tvalid_os, tvalid_ct); end
      end
      checks++; if (2'(dut_os.state) !== 2'd0) begin errors++; $display("FAIL zero_state: got %0d expected 0", dut_os.state); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      logic hit = 1'b0;
      do_reset();
      fill_linear();
      tready_os = 1'b1;
      cfg_os = AW'(10);
      for (int cyc = 1; cyc <= 40 && !hit; cyc++) begin
         @(negedge clk);
         if (tvalid_os) begin
            if (n == 5) hit = 1'b1;
            else begin
               checks++; if (tdata_os !== DW'(n * 3)) begin errors++; $display("FAIL mid_pre_data beat %0d: got %0d expected %0d", n, tdata_os, n * 3); end
               n++;
            end
         end
      end
      checks++; if (!hit) begin errors++; $display("FAIL mid_reach_beat5: got %0d beats expected 5", n); end
      aresetn = 1'b0;
      #1;
      checks++; if (tvalid_os !== 1'b0) begin errors++; $display("FAIL mid_tvalid_drop: got %b expected 0", tvalid_os); end
      checks++; if (en_os !== 1'b0 || sts_os !== '0) begin errors++; $display("FAIL mid_en_sts: got %b/%0d expected 0/0", en_os, sts_os); end
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
      n = 0;
      for (int cyc = 1; cyc <= 40 && n < 10; cyc++) begin
         @(negedge clk);
         if (tvalid_os && tready_os) begin
            checks++; if (tdata_os !== DW'(n * 3)) begin errors++; $display("FAIL mid_restart_data beat %0d: got %0d expected %0d", n, tdata_os, n * 3); end
            n++;
         end
      end
      checks++; if (n != 10) begin errors++; $display("FAIL mid_restart_count: got %0d expected 10", n); end
   endtask

   task automatic test_stall();
      int en_cnt = 0, n = 0;
      do_reset();
      fill_linear();
      tready_os = 1'b0;
      cfg_os = AW'(8);
      repeat (20) begin @(negedge clk); en_cnt += int'(en_os); end
      checks++; if (en_cnt != 2) begin errors++; $display("FAIL stall_reads: got %0d expected 2", en_cnt); end
      checks++; if (sts_os !== AW'(2)) begin errors++; $display("FAIL stall_sts: got %0d expected 2", sts_os); end
      checks++; if (tvalid_os !== 1'b1 || tdata_os !== '0) begin errors++; $display("FAIL stall_head: got %b/%0d expected 1/0", tvalid_os, tdata_os); end
      repeat (10) begin @(negedge clk); en_cnt += int'(en_os); end
      checks++; if (en_cnt != 2 || sts_os !== AW'(2)) begin errors++; $display("FAIL stall_hold: got %0d/%0d expected 2/2", en_cnt, sts_os); end
      tready_os = 1'b1;
      for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (tvalid_os && tready_os) begin
            checks++; if (tdata_os !== DW'(n * 3)) begin errors++; $display("FAIL stall_resume_data beat %0d: got %0d expected %0d", n, tdata_os, n * 3); end
            n++;
         end
      end
      checks++; if (n != 8) begin errors++; $display("FAIL stall_resume_count: got %0d expected 8", n); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b0;
      cfg_os = '0; cfg_ct = '0; tready_os = 1'b0; tready_ct = 1'b0;
      fill_linear();
      test_reset();
      test_oneshot();
      test_continuous();
      test_random_ready();
      test_zero_cfg();
      test_reset_mid();
      test_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
